// File: rtl/router_pkg.sv
// Purpose : Shared types and constants for the 3x1 router sequencing controller.
// Contents: state encoding, port count, invalid address code, timeout defaults,
//           and a helper that turns a port address into a one-hot port select.
package router_pkg;

  localparam int NUM_PORTS   = 3;
  localparam int TIMEOUT     = 30;
  localparam int TIMER_WIDTH = 5;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  function automatic logic [NUM_PORTS-1:0] port_sel(input logic [1:0] addr);
    logic [NUM_PORTS-1:0] sel;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel[i] = (addr == 2'(i));
    end
    return sel;
  endfunction

endpackage

// File: rtl/router_sreset_timer.sv
// Purpose : Read-timeout timer for one destination FIFO. Counts cycles in which
//           the FIFO holds data that nobody reads and emits a one-cycle
//           soft_reset pulse when the limit is reached.
// Ports   : clock_i      rising-edge clock
//           reset_i      synchronous active-high reset
//           vld_i        FIFO holds data (not empty)
//           read_i       downstream read strobe
//           soft_reset_o registered one-cycle timeout pulse
module router_sreset_timer #(
  parameter int TIMEOUT     = 30,
  parameter int TIMER_WIDTH = 5
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic vld_i,
  input  logic read_i,
  output logic soft_reset_o
);

  localparam logic [TIMER_WIDTH-1:0] TERMINAL = TIMER_WIDTH'(TIMEOUT - 1);

  logic [TIMER_WIDTH-1:0] count_q;
  logic                   soft_reset_q;

  // A read on the terminal count clears the timer and suppresses the pulse.
  always_ff @(posedge clock_i) begin
    if (reset_i || !vld_i || read_i) begin
      count_q      <= '0;
      soft_reset_q <= 1'b0;
    end else if (count_q == TERMINAL) begin
      count_q      <= '0;
      soft_reset_q <= 1'b1;
    end else begin
      count_q      <= count_q + 1'b1;
      soft_reset_q <= 1'b0;
    end
  end

  assign soft_reset_o = soft_reset_q;

endmodule

// File: rtl/router_fsm.sv
// Purpose : Packet-sequencing controller for the 3x1 router. Decodes the header
//           address, steps the FIFO write through header/payload/parity phases,
//           stalls on a full FIFO and aborts a packet on a read timeout.
// Ports   : clock_i, reset_i          clock and synchronous active-high reset
//           pkt_valid_i, din_addr_i   input byte valid and header address
//           fifo_full_i, fifo_empty_i per-FIFO status flags
//           read_enb_i                per-FIFO downstream read strobe
//           low_pkt_valid_i           pkt_valid dropped while stalled on full
//           parity_done_i             parity byte already captured
//           write_enb_o               one-hot FIFO write enable
//           write_enb_reg_o           register block may drive FIFO data
//           detect_add_o .. rst_int_reg_o  Moore state flags
//           busy_o                    source must hold its data
//           vld_out_o                 per-FIFO data available
//           soft_reset_o              per-FIFO timeout pulse
//
// state              | meaning
// DECODE_ADDRESS     | idle, header byte decoded when pkt_valid
// WAIT_TILL_EMPTY    | target FIFO still holds an older packet
// LOAD_FIRST_DATA    | header byte written, FIFO tags it
// LOAD_DATA          | payload bytes written while pkt_valid
// FIFO_FULL_STATE    | target FIFO full, writes stalled
// LOAD_AFTER_FULL    | resume after full, byte held by register block written
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | register block compares parity
module router_fsm
  import router_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 pkt_valid_i,
  input  logic [1:0]           din_addr_i,
  input  logic [NUM_PORTS-1:0] fifo_full_i,
  input  logic [NUM_PORTS-1:0] fifo_empty_i,
  input  logic [NUM_PORTS-1:0] read_enb_i,
  input  logic                 low_pkt_valid_i,
  input  logic                 parity_done_i,
  output logic [NUM_PORTS-1:0] write_enb_o,
  output logic                 write_enb_reg_o,
  output logic                 detect_add_o,
  output logic                 lfd_state_o,
  output logic                 ld_state_o,
  output logic                 laf_state_o,
  output logic                 full_state_o,
  output logic                 rst_int_reg_o,
  output logic                 busy_o,
  output logic [NUM_PORTS-1:0] vld_out_o,
  output logic [NUM_PORTS-1:0] soft_reset_o
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic [NUM_PORTS-1:0] write_enb_q;
  logic write_enb_reg_q, detect_add_q, lfd_state_q, ld_state_q;
  logic laf_state_q, full_state_q, rst_int_reg_q, busy_q;

  // Padded to four entries so a 2-bit address always indexes a real bit;
  // the invalid address is filtered before these are consulted.
  logic [3:0] empty_ext, full_ext, sreset_ext;
  assign empty_ext  = {1'b1, fifo_empty_i};
  assign full_ext   = {1'b0, fifo_full_i};
  assign sreset_ext = {1'b0, soft_reset_o};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sreset_timer #(
      .TIMEOUT    (TIMEOUT),
      .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .vld_i       (!fifo_empty_i[i]),
      .read_i      (read_enb_i[i]),
      .soft_reset_o(soft_reset_o[i])
    );
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    // A timeout on the active port abandons the packet from any busy state.
    if (state_q != DECODE_ADDRESS && sreset_ext[addr_q]) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid_i && din_addr_i != ADDR_INVALID) begin
            addr_d  = din_addr_i;
            state_d = empty_ext[din_addr_i] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: if (empty_ext[addr_q]) state_d = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (full_ext[addr_q])  state_d = FIFO_FULL_STATE;
          else if (!pkt_valid_i) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: if (!full_ext[addr_q]) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done_i)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid_i) state_d = LOAD_PARITY;
          else                      state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = full_ext[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet still
  // line up with the state they describe.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= DECODE_ADDRESS;
      addr_q          <= 2'b00;
      write_enb_q     <= '0;
      write_enb_reg_q <= 1'b0;
      detect_add_q    <= 1'b1;
      lfd_state_q     <= 1'b0;
      ld_state_q      <= 1'b0;
      laf_state_q     <= 1'b0;
      full_state_q    <= 1'b0;
      rst_int_reg_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      write_enb_reg_q <= (state_d == LOAD_FIRST_DATA) || (state_d == LOAD_DATA) ||
                         (state_d == LOAD_AFTER_FULL) || (state_d == LOAD_PARITY);
      write_enb_q     <= ((state_d == LOAD_FIRST_DATA) || (state_d == LOAD_DATA) ||
                          (state_d == LOAD_AFTER_FULL) || (state_d == LOAD_PARITY))
                         ? port_sel(addr_d) : '0;
      detect_add_q    <= (state_d == DECODE_ADDRESS);
      lfd_state_q     <= (state_d == LOAD_FIRST_DATA);
      ld_state_q      <= (state_d == LOAD_DATA);
      laf_state_q     <= (state_d == LOAD_AFTER_FULL);
      full_state_q    <= (state_d == FIFO_FULL_STATE);
      rst_int_reg_q   <= (state_d == CHECK_PARITY_ERROR);
      busy_q          <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
    end
  end

  assign write_enb_o     = write_enb_q;
  assign write_enb_reg_o = write_enb_reg_q;
  assign detect_add_o    = detect_add_q;
  assign lfd_state_o     = lfd_state_q;
  assign ld_state_o      = ld_state_q;
  assign laf_state_o     = laf_state_q;
  assign full_state_o    = full_state_q;
  assign rst_int_reg_o   = rst_int_reg_q;
  assign busy_o          = busy_q;
  assign vld_out_o       = ~fifo_empty_i;

endmodule

// File: tb/tb_router_fsm.sv
// Purpose : Self-checking bench for router_fsm. A behavioural model predicts the
//           outputs after every clock edge and queues them; a monitor pops and
//           compares shortly after each edge.
module tb_router_fsm;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] din_addr;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic       low_pkt_valid, parity_done;

  logic [2:0] write_enb, vld_out, soft_reset;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy;

  router_fsm dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .pkt_valid_i    (pkt_valid),
    .din_addr_i     (din_addr),
    .fifo_full_i    (fifo_full),
    .fifo_empty_i   (fifo_empty),
    .read_enb_i     (read_enb),
    .low_pkt_valid_i(low_pkt_valid),
    .parity_done_i  (parity_done),
    .write_enb_o    (write_enb),
    .write_enb_reg_o(write_enb_reg),
    .detect_add_o   (detect_add),
    .lfd_state_o    (lfd_state),
    .ld_state_o     (ld_state),
    .laf_state_o    (laf_state),
    .full_state_o   (full_state),
    .rst_int_reg_o  (rst_int_reg),
    .busy_o         (busy),
    .vld_out_o      (vld_out),
    .soft_reset_o   (soft_reset)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Packet phases named after what the controller is doing, not how it is coded.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_HDR = 2, PH_PAY = 3,
                 PH_STALL = 4, PH_RESUME = 5, PH_PAR = 6, PH_CHK = 7;

  typedef struct packed {
    logic [7:0] flags;   // detect, lfd, ld, laf, full, rst_int, busy, wer
    logic [2:0] we;
    logic [2:0] sr;
  } exp_t;

  exp_t exp_q[$];

  int   m_phase, m_addr, nxt;
  int   m_age [3];
  logic m_sr  [3];

  always @(posedge clock) begin
    exp_t e;
    logic wr;
    if (reset) begin
      m_phase = PH_IDLE;
      m_addr  = 0;
      for (int i = 0; i < 3; i++) begin m_age[i] = 0; m_sr[i] = 1'b0; end
    end else begin
      nxt = m_phase;
      if (m_phase != PH_IDLE && m_sr[m_addr]) nxt = PH_IDLE;
      else begin
        case (m_phase)
          PH_IDLE:   if (pkt_valid && din_addr != 2'd3) begin
                       m_addr = int'(din_addr);
                       nxt = fifo_empty[m_addr] ? PH_HDR : PH_WAIT;
                     end
          PH_WAIT:   if (fifo_empty[m_addr]) nxt = PH_HDR;
          PH_HDR:    nxt = PH_PAY;
          PH_PAY:    if (fifo_full[m_addr]) nxt = PH_STALL;
                     else if (!pkt_valid)   nxt = PH_PAR;
          PH_STALL:  if (!fifo_full[m_addr]) nxt = PH_RESUME;
          PH_RESUME: nxt = parity_done ? PH_IDLE : (low_pkt_valid ? PH_PAR : PH_PAY);
          PH_PAR:    nxt = PH_CHK;
          default:   nxt = fifo_full[m_addr] ? PH_STALL : PH_IDLE;
        endcase
      end
      m_phase = nxt;
      // Each timer measures how long data has sat unread since the last clear.
      for (int i = 0; i < 3; i++) begin
        if (fifo_empty[i] || read_enb[i]) begin
          m_age[i] = 0; m_sr[i] = 1'b0;
        end else begin
          m_age[i]++;
          m_sr[i] = (m_age[i] == TIMEOUT);
          if (m_sr[i]) m_age[i] = 0;
        end
      end
    end
    wr = (m_phase == PH_HDR) || (m_phase == PH_PAY) || (m_phase == PH_RESUME) || (m_phase == PH_PAR);
    e.flags = {m_phase == PH_IDLE, m_phase == PH_HDR, m_phase == PH_PAY, m_phase == PH_RESUME,
               m_phase == PH_STALL, m_phase == PH_CHK,
               !(m_phase == PH_IDLE || m_phase == PH_PAY), wr};
    e.we = wr ? (3'b001 << m_addr) : 3'b000;
    e.sr = {m_sr[2], m_sr[1], m_sr[0]};
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state_flags", {detect_add, lfd_state, ld_state, laf_state, full_state,
                          rst_int_reg, busy, write_enb_reg}, e.flags);
      chk("write_enb",  {5'b0, write_enb},  {5'b0, e.we});
      chk("soft_reset", {5'b0, soft_reset}, {5'b0, e.sr});
      chk("vld_out",    {5'b0, vld_out},    {5'b0, ~fifo_empty});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; pkt_valid = 1'b0; din_addr = 2'd0;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    low_pkt_valid = 1'b0; parity_done = 1'b0;
  endtask

  int mode, stuck;

  initial begin
    idle_inputs();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // header to port 1, four payload bytes, then parity
    pkt_valid = 1'b1; din_addr = 2'd1;
    cyc(1);
    din_addr = 2'd3;
    cyc(4);
    pkt_valid = 1'b0;
    cyc(5);

    // port 2 busy: wait until empty
    fifo_empty = 3'b011; pkt_valid = 1'b1; din_addr = 2'd2;
    cyc(1);
    cyc(3);
    fifo_empty = 3'b111; pkt_valid = 1'b0;
    cyc(6);

    // full stall and resume into parity
    pkt_valid = 1'b1; din_addr = 2'd0;
    cyc(3);
    fifo_full = 3'b001;
    cyc(3);
    fifo_full = 3'b000; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    cyc(1);
    low_pkt_valid = 1'b0;
    cyc(5);

    // timeout pulse on port 0, then a read on cycle 29 suppresses it
    fifo_empty = 3'b110;
    cyc(35);
    fifo_empty = 3'b111;
    cyc(1);
    fifo_empty = 3'b110;
    cyc(28);
    read_enb = 3'b001;
    cyc(1);
    read_enb = 3'b000;
    cyc(10);
    fifo_empty = 3'b111;
    cyc(2);

    // invalid address is ignored
    pkt_valid = 1'b1; din_addr = 2'd3;
    cyc(3);
    // timeout on the active port aborts a packet in LOAD_DATA
    din_addr = 2'd0;
    cyc(3);
    fifo_empty = 3'b110;
    cyc(33);
    idle_inputs();
    cyc(3);

    // mid-packet reset
    pkt_valid = 1'b1; din_addr = 2'd2;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    idle_inputs();
    cyc(2);

    // randomized traffic, in blocks that either behave normally or leave one
    // port unread long enough to time out
    for (int blk = 0; blk < 60; blk++) begin
      mode  = $urandom_range(0, 2);
      stuck = $urandom_range(0, 2);
      for (int c = 0; c < 50; c++) begin
        reset         = ($urandom_range(0, 299) == 0);
        pkt_valid     = ($urandom_range(0, 3) != 0);
        din_addr      = 2'($urandom_range(0, 3));
        low_pkt_valid = ($urandom_range(0, 2) == 0);
        parity_done   = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 3; i++) begin
          fifo_full[i]  = ($urandom_range(0, 9) == 0);
          fifo_empty[i] = ($urandom_range(0, 4) != 0);
          read_enb[i]   = ($urandom_range(0, 4) == 0);
        end
        if (mode == 0) begin
          fifo_empty[stuck] = 1'b0;
          read_enb[stuck]   = 1'b0;
        end
        cyc(1);
      end
    end

    idle_inputs();
    cyc(3);
    if (exp_q.size() > 1) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected at most 1", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
